// File: rtl/ball_motion_update.sv
// ball_motion_update
// ------------------
// Pong ball motion and scoring state machine. Holds the ball at the centre
// of the playfield until a serve, waits a fixed number of frame ticks, then
// applies the velocity supplied by the external collision logic once per
// frame. It bounces the ball off the top and bottom walls, scores misses on
// the left and right edges, and stops the game when a player reaches
// WIN_SCORE.
//
// Ports
//   clk         system clock (single domain)
//   rst_n       synchronous active-low reset
//   frame_tick  one-cycle pulse per video frame
//   serve       start / restart request, level sampled every cycle
//   Vx_In       two's-complement X velocity proposed by the collision logic
//   Vy_In       two's-complement Y velocity proposed by the collision logic
//   Ball_X      ball top-left X position
//   Ball_Y      ball top-left Y position
//   Ball_Vx     current X velocity (two's complement)
//   Ball_Vy     current Y velocity (two's complement)
//   score_p1    player 1 (left paddle) score
//   score_p2    player 2 (right paddle) score
//   point_p1    one-cycle pulse when player 1 scores
//   point_p2    one-cycle pulse when player 2 scores
//   game_over   high while the game is in the OVER state
module ball_motion_update #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int BALL_SIZE     = 10,
    parameter int INIT_VX       = 2,
    parameter int INIT_VY       = 1,
    parameter int SERVE_DELAY   = 60,
    parameter int WIN_SCORE     = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        serve,
    input  logic [15:0] Vx_In,
    input  logic [15:0] Vy_In,
    output logic [15:0] Ball_X,
    output logic [15:0] Ball_Y,
    output logic [15:0] Ball_Vx,
    output logic [15:0] Ball_Vy,
    output logic [3:0]  score_p1,
    output logic [3:0]  score_p2,
    output logic        point_p1,
    output logic        point_p2,
    output logic        game_over
);

    localparam logic [15:0] CENTRE_X = 16'((SCREEN_WIDTH - BALL_SIZE) / 2);
    localparam logic [15:0] CENTRE_Y = 16'((SCREEN_HEIGHT - BALL_SIZE) / 2);
    localparam logic [15:0] MAX_Y_W  = 16'(SCREEN_HEIGHT - BALL_SIZE);

    localparam logic signed [17:0] MAX_X_S = 18'(SCREEN_WIDTH - BALL_SIZE);
    localparam logic signed [17:0] MAX_Y_S = 18'(SCREEN_HEIGHT - BALL_SIZE);

    localparam logic [15:0] SERVE_VX_POS = 16'(INIT_VX);
    localparam logic [15:0] SERVE_VX_NEG = 16'(-INIT_VX);
    localparam logic [15:0] SERVE_VY     = 16'(INIT_VY);

    localparam logic [3:0]  WIN_W = 4'(WIN_SCORE);

    localparam int CNT_W = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_PLAY   = 3'd2,
        S_SCORED = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    state_t            state_q;
    logic [15:0]       ball_x_q;
    logic [15:0]       ball_y_q;
    logic [15:0]       vx_q;
    logic [15:0]       vy_q;
    logic [3:0]        score_p1_q;
    logic [3:0]        score_p2_q;
    logic              point_p1_q;
    logic              point_p2_q;
    logic              game_over_q;
    logic              dir_neg_q;     // next serve goes toward the left (negative X)
    logic [CNT_W-1:0]  wait_cnt_q;

    // Candidate position for this frame, widened to 18-bit signed so that
    // both underflow below zero and overflow past the far edge are visible.
    logic signed [17:0] nx_d;
    logic signed [17:0] ny_d;
    logic [15:0]        vy_neg_d;
    logic [15:0]        serve_vx_d;

    always_comb begin
        nx_d       = $signed({2'b00, ball_x_q}) + $signed({{2{Vx_In[15]}}, Vx_In});
        ny_d       = $signed({2'b00, ball_y_q}) + $signed({{2{Vy_In[15]}}, Vy_In});
        vy_neg_d   = 16'd0 - Vy_In;
        serve_vx_d = dir_neg_q ? SERVE_VX_NEG : SERVE_VX_POS;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ball_x_q    <= CENTRE_X;
            ball_y_q    <= CENTRE_Y;
            vx_q        <= 16'd0;
            vy_q        <= 16'd0;
            score_p1_q  <= 4'd0;
            score_p2_q  <= 4'd0;
            point_p1_q  <= 1'b0;
            point_p2_q  <= 1'b0;
            game_over_q <= 1'b0;
            dir_neg_q   <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            // Point pulses last exactly one cycle.
            point_p1_q <= 1'b0;
            point_p2_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    ball_x_q <= CENTRE_X;
                    ball_y_q <= CENTRE_Y;
                    vx_q     <= 16'd0;
                    vy_q     <= 16'd0;
                    // A tick coinciding with serve is not counted.
                    if (serve) begin
                        state_q    <= S_WAIT;
                        dir_neg_q  <= 1'b0;
                        wait_cnt_q <= '0;
                    end
                end

                S_WAIT: begin
                    if (frame_tick) begin
                        if (wait_cnt_q == CNT_LAST) begin
                            vx_q       <= serve_vx_d;
                            vy_q       <= SERVE_VY;
                            wait_cnt_q <= '0;
                            state_q    <= S_PLAY;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                        end
                    end
                end

                S_PLAY: begin
                    if (frame_tick) begin
                        // Misses win over wall hits; the ball is left where
                        // it was so the scoring frame shows the last position.
                        if (nx_d < 0) begin
                            if (score_p2_q < WIN_W) begin
                                score_p2_q <= score_p2_q + 4'd1;
                            end
                            point_p2_q <= 1'b1;
                            dir_neg_q  <= 1'b1;
                            state_q    <= S_SCORED;
                        end else if (nx_d > MAX_X_S) begin
                            if (score_p1_q < WIN_W) begin
                                score_p1_q <= score_p1_q + 4'd1;
                            end
                            point_p1_q <= 1'b1;
                            dir_neg_q  <= 1'b0;
                            state_q    <= S_SCORED;
                        end else begin
                            ball_x_q <= nx_d[15:0];
                            vx_q     <= Vx_In;
                            if (ny_d < 0) begin
                                ball_y_q <= 16'd0;
                                vy_q     <= vy_neg_d;
                            end else if (ny_d > MAX_Y_S) begin
                                ball_y_q <= MAX_Y_W;
                                vy_q     <= vy_neg_d;
                            end else begin
                                ball_y_q <= ny_d[15:0];
                                vy_q     <= Vy_In;
                            end
                        end
                    end
                end

                S_SCORED: begin
                    if (score_p1_q == WIN_W || score_p2_q == WIN_W) begin
                        state_q     <= S_OVER;
                        game_over_q <= 1'b1;
                    end else begin
                        state_q    <= S_WAIT;
                        ball_x_q   <= CENTRE_X;
                        ball_y_q   <= CENTRE_Y;
                        vx_q       <= 16'd0;
                        vy_q       <= 16'd0;
                        wait_cnt_q <= '0;
                    end
                end

                S_OVER: begin
                    // Ball and scores stay frozen until a new game is served.
                    if (serve) begin
                        state_q     <= S_WAIT;
                        game_over_q <= 1'b0;
                        score_p1_q  <= 4'd0;
                        score_p2_q  <= 4'd0;
                        dir_neg_q   <= 1'b0;
                        ball_x_q    <= CENTRE_X;
                        ball_y_q    <= CENTRE_Y;
                        vx_q        <= 16'd0;
                        vy_q        <= 16'd0;
                        wait_cnt_q  <= '0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Ball_X    = ball_x_q;
    assign Ball_Y    = ball_y_q;
    assign Ball_Vx   = vx_q;
    assign Ball_Vy   = vy_q;
    assign score_p1  = score_p1_q;
    assign score_p2  = score_p2_q;
    assign point_p1  = point_p1_q;
    assign point_p2  = point_p2_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_ball_motion_update.sv
// tb_ball_motion_update
// ---------------------
// Directed bench for ball_motion_update with hand-computed expectations:
// serve launch timing, wall bounces, a miss that coincides with a wall hit,
// a full game to WIN_SCORE, and a reset issued during play.
module tb_ball_motion_update;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic        serve;
    logic [15:0] Vx_In;
    logic [15:0] Vy_In;
    logic [15:0] Ball_X;
    logic [15:0] Ball_Y;
    logic [15:0] Ball_Vx;
    logic [15:0] Ball_Vy;
    logic [3:0]  score_p1;
    logic [3:0]  score_p2;
    logic        point_p1;
    logic        point_p2;
    logic        game_over;

    int n_checks = 0;
    int n_pass   = 0;

    ball_motion_update dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .serve      (serve),
        .Vx_In      (Vx_In),
        .Vy_In      (Vy_In),
        .Ball_X     (Ball_X),
        .Ball_Y     (Ball_Y),
        .Ball_Vx    (Ball_Vx),
        .Ball_Vy    (Ball_Vy),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .point_p1   (point_p1),
        .point_p2   (point_p2),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-16s got=%0d exp=%0d ok", tag, got, exp);
        end else begin
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One frame tick with the given velocity proposal; returns on the
    // falling edge after the sampling edge, where the update is visible.
    task automatic do_tick(input int vx, input int vy);
        @(negedge clk);
        Vx_In      = 16'(vx);
        Vy_In      = 16'(vy);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic do_serve();
        @(negedge clk);
        serve = 1'b1;
        @(negedge clk);
        serve = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) do_tick(0, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        serve      = 1'b0;
        Vx_In      = 16'd0;
        Vy_In      = 16'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_x", Ball_X, 32'd315);
        check_eq("rst_y", Ball_Y, 32'd235);
        check_eq("rst_vx", Ball_Vx, 32'd0);
        check_eq("rst_vy", Ball_Vy, 32'd0);
        check_eq("rst_s1", score_p1, 32'd0);
        check_eq("rst_s2", score_p2, 32'd0);
        check_eq("rst_over", game_over, 32'd0);
        rst_n = 1'b1;

        // Ticks in IDLE do nothing
        do_tick(7, 7);
        check_eq("idle_tick_x", Ball_X, 32'd315);

        // Serve together with a tick: that tick must not count
        @(negedge clk);
        serve      = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        serve      = 1'b0;
        frame_tick = 1'b0;
        wait_ticks(59);
        check_eq("wait59_vx", Ball_Vx, 32'd0);
        do_tick(0, 0);
        check_eq("launch_vx", Ball_Vx, 32'd2);
        check_eq("launch_vy", Ball_Vy, 32'd1);
        check_eq("launch_x", Ball_X, 32'd315);

        // First PLAY tick, with serve held high (ignored in PLAY)
        serve = 1'b1;
        do_tick(2, 1);
        serve = 1'b0;
        check_eq("play1_x", Ball_X, 32'd317);
        check_eq("play1_y", Ball_Y, 32'd236);

        // Top wall: move to Y=1, then Vy=-3
        do_tick(0, -235);
        check_eq("to_y1", Ball_Y, 32'd1);
        do_tick(0, -3);
        check_eq("top_y", Ball_Y, 32'd0);
        check_eq("top_vy", Ball_Vy, 32'd3);

        // Bottom wall: move to Y=468, then Vy=4
        do_tick(0, 468);
        check_eq("to_y468", Ball_Y, 32'd468);
        do_tick(0, 4);
        check_eq("bot_y", Ball_Y, 32'd470);
        check_eq("bot_vy", Ball_Vy, 32'hFFFC);
        check_eq("bot_x", Ball_X, 32'd317);

        // Left miss with simultaneous top hit: X=1, Y=0 first
        do_tick(-316, -470);
        check_eq("to_x1", Ball_X, 32'd1);
        check_eq("to_y0", Ball_Y, 32'd0);
        do_tick(-2, -1);
        check_eq("lmiss_pt2", point_p2, 32'd1);
        check_eq("lmiss_pt1", point_p1, 32'd0);
        check_eq("lmiss_s2", score_p2, 32'd1);
        check_eq("lmiss_hold_x", Ball_X, 32'd1);
        @(negedge clk);
        check_eq("lmiss_pulse_end", point_p2, 32'd0);
        check_eq("recentre_x", Ball_X, 32'd315);
        check_eq("recentre_y", Ball_Y, 32'd235);
        wait_ticks(60);
        check_eq("reserve_vx", Ball_Vx, 32'hFFFE);
        check_eq("reserve_vy", Ball_Vy, 32'd1);

        // Right misses until player 1 wins
        for (int i = 1; i <= 7; i++) begin
            do_tick(400, 0);
            check_eq("rmiss_pt1", point_p1, 32'd1);
            @(negedge clk);
            check_eq("rmiss_s1", score_p1, 32'(i));
            if (i < 7) begin
                check_eq("rmiss_no_over", game_over, 32'd0);
                wait_ticks(60);
            end
        end
        check_eq("win_over", game_over, 32'd1);
        check_eq("win_s2", score_p2, 32'd1);
        do_tick(5, 5);
        do_tick(5, 5);
        check_eq("over_x", Ball_X, 32'd315);
        check_eq("over_y", Ball_Y, 32'd235);
        check_eq("over_s1", score_p1, 32'd7);

        // Serve in OVER clears scores and enters WAIT
        do_serve();
        check_eq("new_s1", score_p1, 32'd0);
        check_eq("new_s2", score_p2, 32'd0);
        check_eq("new_over", game_over, 32'd0);
        check_eq("new_vx", Ball_Vx, 32'd0);
        wait_ticks(59);
        check_eq("new_wait_vx", Ball_Vx, 32'd0);
        do_tick(0, 0);
        check_eq("new_launch_vx", Ball_Vx, 32'd2);

        // Score a point, relaunch, move, then reset mid-PLAY
        do_tick(-400, 0);
        check_eq("pre_rst_s2", score_p2, 32'd1);
        @(negedge clk);
        wait_ticks(60);
        do_tick(5, -5);
        check_eq("pre_rst_x", Ball_X, 32'd320);
        check_eq("pre_rst_y", Ball_Y, 32'd230);
        @(negedge clk);
        rst_n      = 1'b0;
        frame_tick = 1'b1;
        Vx_In      = 16'd5;
        Vy_In      = 16'd5;
        @(negedge clk);
        rst_n      = 1'b1;
        frame_tick = 1'b0;
        check_eq("mrst_x", Ball_X, 32'd315);
        check_eq("mrst_y", Ball_Y, 32'd235);
        check_eq("mrst_vx", Ball_Vx, 32'd0);
        check_eq("mrst_vy", Ball_Vy, 32'd0);
        check_eq("mrst_s2", score_p2, 32'd0);
        do_tick(5, 5);
        check_eq("mrst_idle_x", Ball_X, 32'd315);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
